// File: rtl/me_window_feeder_pkg.sv
// rtl/me_window_feeder_pkg.sv - shared types and constants for the motion-estimation window feeder
package me_pkg;
    localparam int MACRO_DIM_DEF  = 16;
    localparam int SEARCH_DIM_DEF = 48;
    localparam int STRIPS         = SEARCH_DIM_DEF - MACRO_DIM_DEF + 1;

    typedef logic [7:0] pixel_t;
    typedef pixel_t [MACRO_DIM_DEF-1:0] pixel_row_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } feed_state_t;

    // Number of horizontal candidate positions for a given macroblock/search geometry.
    function automatic int strips_for(input int macro_dim, input int search_dim);
        return search_dim - macro_dim + 1;
    endfunction
endpackage

// File: rtl/me_window_feeder_if.sv
// rtl/me_window_feeder_if.sv - control, memory-read and pixel-row bundle between feeder and its neighbours
interface me_window_feeder_if #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48
);
    import me_pkg::*;

    localparam int RW = $clog2(SEARCH_DIM);
    localparam int CW = $clog2(MACRO_DIM);

    logic                     start;
    logic                     busy;
    logic                     done;
    logic                     spr_rd;
    logic [RW-1:0]            spr_row;
    logic [RW-1:0]            spr_col;
    pixel_t [MACRO_DIM-1:0]   spr_rdata;
    logic                     cpr_rd;
    logic [CW-1:0]            cpr_row;
    pixel_t [MACRO_DIM-1:0]   cpr_rdata;
    pixel_t [MACRO_DIM-1:0]   pixel_spr_out;
    pixel_t [MACRO_DIM-1:0]   pixel_cpr_out;
    logic                     en_spr;
    logic                     en_cpr;
    logic                     me_start;

    modport slave (
        input  start, spr_rdata, cpr_rdata,
        output busy, done, spr_rd, spr_row, spr_col, cpr_rd, cpr_row,
               pixel_spr_out, pixel_cpr_out, en_spr, en_cpr, me_start
    );

    modport master (
        output start, spr_rdata, cpr_rdata,
        input  busy, done, spr_rd, spr_row, spr_col, cpr_rd, cpr_row,
               pixel_spr_out, pixel_cpr_out, en_spr, en_cpr, me_start
    );
endinterface

// File: rtl/me_window_feeder_cpr_row_buf.sv
// rtl/me_window_feeder_cpr_row_buf.sv - macroblock row register file, one write port, one registered read port
module cpr_row_buf
    import me_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int PIXELS = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  pixel_t [PIXELS-1:0]   wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output pixel_t [PIXELS-1:0]   rdata_o
);
    pixel_t [PIXELS-1:0] mem_q [DEPTH];
    pixel_t [PIXELS-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/me_window_feeder.sv
// rtl/me_window_feeder.sv - walks every strip of the search window, streaming aligned search/current rows to me
// ME_FEED_CPR_CACHE_EN: fetch current-MB rows once in strip 0 and replay them from cpr_row_buf afterwards.
module me_window_feeder
    import me_pkg::*;
#(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48
) (
    input  logic               clk,
    input  logic               rst,
    me_window_feeder_if.slave  bus
);
    localparam int RW      = $clog2(SEARCH_DIM);
    localparam int CW      = $clog2(MACRO_DIM);
    localparam int NSTRIPS = strips_for(MACRO_DIM, SEARCH_DIM);
    localparam logic [RW-1:0] ROW_LAST   = RW'(SEARCH_DIM - 1);
    localparam logic [RW-1:0] STRIP_LAST = RW'(NSTRIPS - 1);
    localparam logic [RW-1:0] CPR_LAST   = RW'(MACRO_DIM - 1);
`ifdef ME_FEED_CPR_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    feed_state_t   state_q;
    logic [RW-1:0] r_q, s_q;
    logic [CW-1:0] cpr_row_q;
    logic          busy_q, done_q, spr_rd_q, cpr_req_q, cpr_rd_q, first_q, drain_q;

    // cpr_req_q marks a current row due this cycle; cpr_rd_q is the subset that hits memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            r_q       <= '0;
            s_q       <= '0;
            cpr_row_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            spr_rd_q  <= 1'b0;
            cpr_req_q <= 1'b0;
            cpr_rd_q  <= 1'b0;
            first_q   <= 1'b0;
            drain_q   <= 1'b0;
        end else begin
            first_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q   <= ST_FETCH;
                        busy_q    <= 1'b1;
                        spr_rd_q  <= 1'b1;
                        cpr_req_q <= 1'b1;
                        cpr_rd_q  <= 1'b1;
                        first_q   <= 1'b1;
                        r_q       <= '0;
                        s_q       <= '0;
                        cpr_row_q <= '0;
                    end
                end
                ST_FETCH: begin
                    if (r_q == ROW_LAST) begin
                        r_q       <= '0;
                        cpr_row_q <= '0;
                        if (s_q == STRIP_LAST) begin
                            state_q   <= ST_DRAIN;
                            drain_q   <= 1'b0;
                            spr_rd_q  <= 1'b0;
                            cpr_req_q <= 1'b0;
                            cpr_rd_q  <= 1'b0;
                            s_q       <= '0;
                        end else begin
                            s_q       <= s_q + 1'b1;
                            cpr_req_q <= 1'b1;
                            cpr_rd_q  <= !CACHE_EN;
                        end
                    end else begin
                        r_q <= r_q + 1'b1;
                        if (r_q < CPR_LAST) begin
                            cpr_req_q <= 1'b1;
                            cpr_rd_q  <= !CACHE_EN || (s_q == '0);
                            cpr_row_q <= cpr_row_q + 1'b1;
                        end else begin
                            cpr_req_q <= 1'b0;
                            cpr_rd_q  <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Two cycles: memory latency plus the output register stage.
                    if (drain_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    logic                   spr_d1, cpr_d1, first_d1;
    logic                   en_spr_q, en_cpr_q, me_start_q;
    pixel_t [MACRO_DIM-1:0] pix_spr_q, pix_cpr_q, cpr_src;

`ifdef ME_FEED_CPR_CACHE_EN
    logic                   replay_d1, fill_d1;
    logic [CW-1:0]          row_d1;
    pixel_t [MACRO_DIM-1:0] buf_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            replay_d1 <= 1'b0;
            fill_d1   <= 1'b0;
            row_d1    <= '0;
        end else begin
            replay_d1 <= cpr_req_q & ~cpr_rd_q;
            fill_d1   <= cpr_rd_q;
            row_d1    <= cpr_row_q;
        end
    end

    cpr_row_buf #(
        .DEPTH  (MACRO_DIM),
        .PIXELS (MACRO_DIM),
        .AW     (CW)
    ) u_cpr_row_buf (
        .clk     (clk),
        .rst     (rst),
        .we_i    (fill_d1),
        .waddr_i (row_d1),
        .wdata_i (bus.cpr_rdata),
        .re_i    (cpr_req_q & ~cpr_rd_q),
        .raddr_i (cpr_row_q),
        .rdata_o (buf_rdata)
    );

    assign cpr_src = replay_d1 ? buf_rdata : bus.cpr_rdata;
`else
    assign cpr_src = bus.cpr_rdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            spr_d1     <= 1'b0;
            cpr_d1     <= 1'b0;
            first_d1   <= 1'b0;
            en_spr_q   <= 1'b0;
            en_cpr_q   <= 1'b0;
            me_start_q <= 1'b0;
            pix_spr_q  <= '0;
            pix_cpr_q  <= '0;
        end else begin
            spr_d1     <= spr_rd_q;
            cpr_d1     <= cpr_req_q;
            first_d1   <= first_q;
            en_spr_q   <= spr_d1;
            en_cpr_q   <= cpr_d1;
            me_start_q <= first_d1;
            if (spr_d1) begin
                pix_spr_q <= bus.spr_rdata;
            end
            if (cpr_d1) begin
                pix_cpr_q <= cpr_src;
            end
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.spr_rd        = spr_rd_q;
    assign bus.spr_row       = r_q;
    assign bus.spr_col       = s_q;
    assign bus.cpr_rd        = cpr_rd_q;
    assign bus.cpr_row       = cpr_row_q;
    assign bus.pixel_spr_out = pix_spr_q;
    assign bus.pixel_cpr_out = pix_cpr_q;
    assign bus.en_spr        = en_spr_q;
    assign bus.en_cpr        = en_cpr_q;
    assign bus.me_start      = me_start_q;
endmodule

// File: tb/tb_me_window_feeder.sv
// tb/tb_me_window_feeder.sv - randomized scoreboard bench for me_window_feeder
module tb_me_window_feeder;
    import me_pkg::*;

    localparam int MD         = 16;
    localparam int SD         = 48;
    localparam int RW         = $clog2(SD);
    localparam int CW         = $clog2(MD);
    localparam int NS         = SD - MD + 1;
    localparam int LAST_ISSUE = NS * SD;
    localparam int DONE_REL   = LAST_ISSUE + 3;
    localparam int ME_REL     = 3;
`ifdef ME_FEED_CPR_CACHE_EN
    localparam int EXP_CPR_RD = MD;
`else
    localparam int EXP_CPR_RD = NS * MD;
`endif

    typedef pixel_t [MD-1:0] row_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    me_window_feeder_if #(.MACRO_DIM(MD), .SEARCH_DIM(SD)) bus ();
    me_window_feeder #(.MACRO_DIM(MD), .SEARCH_DIM(SD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    me_window_feeder_if #(.MACRO_DIM(4), .SEARCH_DIM(8)) sbus ();
    me_window_feeder #(.MACRO_DIM(4), .SEARCH_DIM(8)) sdut (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;
    bit   active = 1'b0;
    int   t0 = 0;
    int   key = 0;
    int   n_spr_rd = 0, n_cpr_rd = 0, n_done = 0;
    int   s_en_cnt = 0, s_done_cyc = 0, s_done_n = 0;
    row_t exp_spr[$];
    row_t exp_cpr[$];
    row_t last_spr = '0, last_cpr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_row(input string name, input row_t act, input row_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic row_t spr_row_f(input int r, input int c, input int k);
        row_t v;
        for (int i = 0; i < MD; i++) v[i] = pixel_t'((r * 3 + c + i + k) % 256);
        return v;
    endfunction

    function automatic row_t cpr_row_f(input int r, input int k);
        row_t v;
        for (int i = 0; i < MD; i++) v[i] = pixel_t'((r * 5 + i * 7 + k * 11 + 1) % 256);
        return v;
    endfunction

    function automatic row_t rand_row();
        row_t v;
        for (int i = 0; i < MD; i++) v[i] = pixel_t'($urandom_range(0, 255));
        return v;
    endfunction

    // Memory model: returns data one cycle after the read; garbage whenever no read is pending.
    always @(posedge clk) begin : mem_model
        logic          s_rd, c_rd;
        logic [RW-1:0] sr, sc;
        logic [CW-1:0] cr;
        s_rd = bus.spr_rd;
        c_rd = bus.cpr_rd;
        sr   = bus.spr_row;
        sc   = bus.spr_col;
        cr   = bus.cpr_row;
        #1;
        bus.spr_rdata = s_rd ? spr_row_f(int'(sr), int'(sc), key) : rand_row();
        bus.cpr_rdata = c_rd ? cpr_row_f(int'(cr), key) : rand_row();
    end

    always @(negedge clk) begin : monitor
        int rel;
        bit in_win;
        rel    = cyc - t0;
        in_win = active && rel >= 1 && rel <= DONE_REL;
        if (mon_en) begin
            check_int("busy", int'(bus.busy), int'(in_win));
            if (bus.spr_rd) n_spr_rd++;
            if (bus.cpr_rd) n_cpr_rd++;
            if (bus.en_spr) begin
                if (exp_spr.size() == 0) check_int("en_spr_unexpected", 1, 0);
                else check_row("pixel_spr", bus.pixel_spr_out, exp_spr.pop_front());
                last_spr = bus.pixel_spr_out;
            end else begin
                check_row("spr_hold", bus.pixel_spr_out, last_spr);
            end
            if (bus.en_cpr) begin
                if (exp_cpr.size() == 0) check_int("en_cpr_unexpected", 1, 0);
                else check_row("pixel_cpr", bus.pixel_cpr_out, exp_cpr.pop_front());
                last_cpr = bus.pixel_cpr_out;
            end else begin
                check_row("cpr_hold", bus.pixel_cpr_out, last_cpr);
            end
            if (bus.me_start || (in_win && rel == ME_REL)) begin
                check_int("me_start", int'(bus.me_start), int'(in_win && rel == ME_REL));
                check_int("me_start_with_en_spr", int'(bus.en_spr), 1);
            end
            if (bus.done || (in_win && rel == DONE_REL)) begin
                check_int("done", int'(bus.done), int'(in_win && rel == DONE_REL));
                if (bus.done) begin
                    n_done++;
                    check_int("spr_rows_missing", exp_spr.size(), 0);
                    check_int("cpr_rows_missing", exp_cpr.size(), 0);
                    check_int("spr_rd_count", n_spr_rd, LAST_ISSUE);
                    check_int("cpr_rd_count", n_cpr_rd, EXP_CPR_RD);
                end
            end
        end
        if (sbus.en_spr) s_en_cnt++;
        if (sbus.done) begin
            s_done_cyc = cyc;
            s_done_n++;
        end
    end

    task automatic start_at(input int e, input int newkey);
        bit acc;
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
        bus.start = 1'b1;
        @(posedge clk);
        acc = !active || (e >= t0 + DONE_REL + 1);
        #1 bus.start = 1'b0;
        if (acc) begin
            active   = 1'b1;
            t0       = e;
            key      = newkey;
            n_spr_rd = 0;
            n_cpr_rd = 0;
            for (int s = 0; s < NS; s++) begin
                for (int r = 0; r < SD; r++) begin
                    exp_spr.push_back(spr_row_f(r, s, key));
                    if (r < MD) exp_cpr.push_back(cpr_row_f(r, key));
                end
            end
        end
    endtask

    task automatic reset_at(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        active   = 1'b0;
        last_spr = '0;
        last_cpr = '0;
        exp_spr.delete();
        exp_cpr.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int se;
        bus.start       = 1'b0;
        sbus.start      = 1'b0;
        sbus.spr_rdata  = '0;
        sbus.cpr_rdata  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_int("idle_ctrl", int'({bus.busy, bus.done, bus.spr_rd, bus.cpr_rd,
                                         bus.en_spr, bus.en_cpr, bus.me_start}), 0);
            check_int("idle_addr", int'({bus.spr_row, bus.spr_col, bus.cpr_row}), 0);
            check_row("idle_pix_spr", bus.pixel_spr_out, '0);
            check_row("idle_pix_cpr", bus.pixel_cpr_out, '0);
        end
        mon_en = 1'b1;

        // Window 1 with the plain pattern, ignored starts at 100 and in the DONE cycle, then back-to-back.
        start_at(cyc + 1, 0);
        start_at(t0 + 100, int'($urandom_range(1, 255)));
        start_at(t0 + DONE_REL, int'($urandom_range(1, 255)));
        start_at(t0 + DONE_REL + 1, int'($urandom_range(1, 255)));

        // Window 2 aborted by reset, window 3 started in the first cycle after reset.
        reset_at(t0 + 500);
        start_at(cyc, int'($urandom_range(0, 255)));
        for (int j = 0; j < 4; j++) begin
            start_at(t0 + 200 + j * 300 + int'($urandom_range(0, 100)), int'($urandom_range(0, 255)));
        end
        start_at(t0 + DONE_REL, int'($urandom_range(0, 255)));
        while (cyc < t0 + DONE_REL + 10) @(posedge clk);
        check_int("done_count", n_done, 2);

        // Small geometry: 5 strips x 8 rows.
        @(posedge clk);
        #1 sbus.start = 1'b1;
        se = cyc;
        @(posedge clk);
        #1 sbus.start = 1'b0;
        repeat (60) @(posedge clk);
        check_int("small_en_spr_count", s_en_cnt, 40);
        check_int("small_done_count", s_done_n, 1);
        check_int("small_done_cycle", s_done_cyc - se, 43);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
